// File: rtl/chip_burst_sequencer_pkg.sv
// rtl/chip_burst_sequencer_pkg.sv - shared types and column helper for the Chip burst sequencer
package chip_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Sequential burst order: low lbl bits advance and wrap inside the aligned block.
    function automatic logic [31:0] burst_col(input logic [31:0] start,
                                              input logic [31:0] beat,
                                              input int          lbl);
        logic [31:0] mask;
        mask = (32'd1 << lbl) - 32'd1;
        return (start & ~mask) | ((start + beat) & mask);
    endfunction

endpackage

// File: rtl/chip_burst_sequencer_if.sv
// rtl/chip_burst_sequencer_if.sv - burst request / read response bundle
interface chip_burst_sequencer_if #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int CHWIDTH      = 5,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [BGWIDTH-1:0]           req_bg;
    logic [BAWIDTH-1:0]           req_ba;
    logic [CHWIDTH-1:0]           req_row;
    logic [COLWIDTH-1:0]          req_col;
    logic [BL*DEVICE_WIDTH-1:0]   req_wdata;
    logic                         rd_resp_valid;
    logic [BL*DEVICE_WIDTH-1:0]   rd_resp_data;

    modport master (
        output req_valid, req_write, req_bg, req_ba, req_row, req_col, req_wdata,
        input  req_ready, rd_resp_valid, rd_resp_data
    );

    modport slave (
        input  req_valid, req_write, req_bg, req_ba, req_row, req_col, req_wdata,
        output req_ready, rd_resp_valid, rd_resp_data
    );
endinterface

// File: rtl/chip_burst_sequencer_rd_capture.sv
// rtl/chip_burst_sequencer_rd_capture.sv - read-latency delay line and dqout slot capture
module chip_seq_rd_capture #(
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int READ_LAT     = 1,
    localparam int LBL         = $clog2(BL),
    localparam int IW          = (LBL > 0) ? LBL : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       beat_fire,
    input  logic [IW-1:0]              beat_idx,
    input  logic [DEVICE_WIDTH-1:0]    dq,
    output logic                       cap_done,
    output logic                       resp_valid,
    output logic [BL*DEVICE_WIDTH-1:0] resp_data
);
    // Stage 0 marks the cycle a beat is on the pins; stage READ_LAT is when dqout is valid.
    localparam int D = READ_LAT + 1;

    logic [D-1:0]  vld;
    logic [IW-1:0] idx [D];

    assign cap_done = vld[D-1] && (idx[D-1] == IW'(BL - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            for (int k = 0; k < D; k++) idx[k] <= '0;
        end else begin
            vld        <= {vld[D-2:0], beat_fire};
            idx[0]     <= beat_idx;
            for (int k = 1; k < D; k++) idx[k] <= idx[k-1];
            resp_valid <= cap_done;
            if (vld[D-1]) resp_data[idx[D-1]*DEVICE_WIDTH +: DEVICE_WIDTH] <= dq;
        end
    end
endmodule

// File: rtl/chip_burst_sequencer.sv
// rtl/chip_burst_sequencer.sv - turns single-request bursts into per-bank per-beat Chip drive
module chip_burst_sequencer
    import chip_seq_pkg::*;
#(
    parameter int BGWIDTH      = 2,
    parameter int BANKGROUPS   = 4,
    parameter int BAWIDTH      = 2,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int READ_LAT     = 1,
    localparam int BANKSPERGROUP = 2**BAWIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    chip_burst_sequencer_if.slave   req,
    output logic                    rd_o_wr [BANKGROUPS][BANKSPERGROUP],
    output logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS][BANKSPERGROUP],
    output logic [CHWIDTH-1:0]      row     [BANKGROUPS][BANKSPERGROUP],
    output logic [COLWIDTH-1:0]     column  [BANKGROUPS][BANKSPERGROUP],
    input  logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS][BANKSPERGROUP]
);
    localparam int LBL = $clog2(BL);
    localparam int CW  = LBL + 1;
    localparam int IW  = (LBL > 0) ? LBL : 1;
    localparam int DW  = DEVICE_WIDTH;
    localparam int WW  = BL * DW;

    state_e              state;
    logic [CW-1:0]       beat_cnt;
    logic                lat_write;
    logic [BGWIDTH-1:0]  lat_bg;
    logic [BAWIDTH-1:0]  lat_ba;
    logic [CHWIDTH-1:0]  lat_row;
    logic [COLWIDTH-1:0] lat_col;
    logic [WW-1:0]       lat_wdata;

    logic                accept, load_beat, cap_done;
    logic                s_write;
    logic [BGWIDTH-1:0]  s_bg;
    logic [BAWIDTH-1:0]  s_ba;
    logic [CHWIDTH-1:0]  s_row;
    logic [COLWIDTH-1:0] s_col;
    logic [WW-1:0]       s_wdata;
    logic [IW-1:0]       beat_idx;
    logic [COLWIDTH-1:0] beat_col;
    logic [DW-1:0]       beat_dq;
    logic [DW-1:0]       sel_dq;
    logic                hit [BANKGROUPS][BANKSPERGROUP];

    assign accept    = (state == IDLE) && req.req_valid;
    assign load_beat = accept || ((state == BURST) && (beat_cnt < CW'(BL)));

    // Beat 0 is driven on the accept edge, straight from the request fields.
    assign s_write  = accept ? req.req_write : lat_write;
    assign s_bg     = accept ? req.req_bg    : lat_bg;
    assign s_ba     = accept ? req.req_ba    : lat_ba;
    assign s_row    = accept ? req.req_row   : lat_row;
    assign s_col    = accept ? req.req_col   : lat_col;
    assign s_wdata  = accept ? req.req_wdata : lat_wdata;
    assign beat_idx = accept ? '0 : beat_cnt[IW-1:0];
    assign beat_col = COLWIDTH'(burst_col(32'(s_col), 32'(beat_idx), LBL));
    assign beat_dq  = s_write ? s_wdata[beat_idx*DW +: DW] : '0;
    assign sel_dq   = dqout[lat_bg][lat_ba];

    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_bg
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_ba
            assign hit[g][b] = load_beat && (s_bg == BGWIDTH'(g)) && (s_ba == BAWIDTH'(b));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req.req_ready <= 1'b1;
            beat_cnt  <= '0;
            lat_write <= 1'b0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write     <= req.req_write;
                        lat_bg        <= req.req_bg;
                        lat_ba        <= req.req_ba;
                        lat_row       <= req.req_row;
                        lat_col       <= req.req_col;
                        lat_wdata     <= req.req_wdata;
                        beat_cnt      <= CW'(1);
                        req.req_ready <= 1'b0;
                        state         <= BURST;
                    end
                end
                BURST: begin
                    if (beat_cnt == CW'(BL)) begin
                        if (lat_write) begin
                            state         <= IDLE;
                            req.req_ready <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cap_done) begin
                        state         <= IDLE;
                        req.req_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req.req_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < BANKGROUPS; g++) begin
                for (int b = 0; b < BANKSPERGROUP; b++) begin
                    rd_o_wr[g][b] <= 1'b0;
                    dqin[g][b]    <= '0;
                    row[g][b]     <= '0;
                    column[g][b]  <= '0;
                end
            end
        end else begin
            for (int g = 0; g < BANKGROUPS; g++) begin
                for (int b = 0; b < BANKSPERGROUP; b++) begin
                    rd_o_wr[g][b] <= hit[g][b] ? s_write  : 1'b0;
                    dqin[g][b]    <= hit[g][b] ? beat_dq  : '0;
                    row[g][b]     <= hit[g][b] ? s_row    : '0;
                    column[g][b]  <= hit[g][b] ? beat_col : '0;
                end
            end
        end
    end

    chip_seq_rd_capture #(
        .DEVICE_WIDTH (DEVICE_WIDTH),
        .BL           (BL),
        .READ_LAT     (READ_LAT)
    ) u_rd_capture (
        .clk        (clk),
        .reset_n    (reset_n),
        .beat_fire  (load_beat && !s_write),
        .beat_idx   (beat_idx),
        .dq         (sel_dq),
        .cap_done   (cap_done),
        .resp_valid (req.rd_resp_valid),
        .resp_data  (req.rd_resp_data)
    );
endmodule

// File: tb/tb_chip_burst_sequencer.sv
// tb/tb_chip_burst_sequencer.sv - directed bench for chip_burst_sequencer with a small Chip model
module tb_chip_burst_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    chip_burst_sequencer_if #(
        .BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(5), .COLWIDTH(10), .DEVICE_WIDTH(4), .BL(8)
    ) bus ();

    logic       rd_o_wr [4][4];
    logic [3:0] dqin    [4][4];
    logic [4:0] row     [4][4];
    logic [9:0] column  [4][4];
    logic [3:0] dqout   [4][4];

    chip_burst_sequencer #(
        .BGWIDTH(2), .BANKGROUPS(4), .BAWIDTH(2), .COLWIDTH(10), .CHWIDTH(5),
        .DEVICE_WIDTH(4), .BL(8), .READ_LAT(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus),
        .rd_o_wr (rd_o_wr),
        .dqin    (dqin),
        .row     (row),
        .column  (column),
        .dqout   (dqout)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] mem [int];

    // Chip model: writes land on the edge, reads return one cycle later (READ_LAT=1).
    always @(posedge clk) begin : chip_model
        int key;
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) begin
                key = (g << 17) | (b << 15) | (int'(row[g][b]) << 10) | int'(column[g][b]);
                if (rd_o_wr[g][b]) mem[key] = dqin[g][b];
                else dqout[g][b] <= mem.exists(key) ? mem[key] : 4'h0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int busy_except(input int bg, input int ba);
        int n;
        n = 0;
        for (int g = 0; g < 4; g++)
            for (int b = 0; b < 4; b++)
                if (!(g == bg && b == ba) &&
                    (rd_o_wr[g][b] !== 1'b0 || dqin[g][b] !== 4'h0 ||
                     row[g][b] !== 5'h0 || column[g][b] !== 10'h0))
                    n++;
        return n;
    endfunction

    task automatic start_req(input logic wr, input int bg, input int ba, input logic [4:0] r,
                             input logic [9:0] c, input logic [31:0] wd, input bit hold);
        check("acc_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_bg    = 2'(bg);
        bus.req_ba    = 2'(ba);
        bus.req_row   = r;
        bus.req_col   = c;
        bus.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic check_beats(input string tag, input logic wr, input int bg, input int ba,
                               input logic [4:0] r, input logic [9:0] c, input logic [31:0] wd,
                               input int nbeats);
        logic [9:0] ec;
        logic [3:0] ed;
        for (int i = 0; i < nbeats; i++) begin
            ec = (c & 10'h3F8) | ((c + 10'(i)) & 10'h007);
            ed = wr ? wd[i*4 +: 4] : 4'h0;
            check($sformatf("%s_b%0d_wr", tag, i),    64'(rd_o_wr[bg][ba]), 64'(wr));
            check($sformatf("%s_b%0d_col", tag, i),   64'(column[bg][ba]),  64'(ec));
            check($sformatf("%s_b%0d_row", tag, i),   64'(row[bg][ba]),     64'(r));
            check($sformatf("%s_b%0d_dqin", tag, i),  64'(dqin[bg][ba]),    64'(ed));
            check($sformatf("%s_b%0d_rdy", tag, i),   64'(bus.req_ready),   64'd0);
            check($sformatf("%s_b%0d_other", tag, i), 64'(busy_except(bg, ba)), 64'd0);
            @(negedge clk);
        end
    endtask

    task automatic do_write(input string tag, input int bg, input int ba, input logic [4:0] r,
                            input logic [9:0] c, input logic [31:0] wd);
        start_req(1'b1, bg, ba, r, c, wd, 1'b0);
        check_beats(tag, 1'b1, bg, ba, r, c, wd, 8);
        check({tag, "_end_rdy"},  64'(bus.req_ready), 64'd1);
        check({tag, "_end_idle"}, 64'(busy_except(-1, -1)), 64'd0);
    endtask

    task automatic do_read(input string tag, input int bg, input int ba, input logic [4:0] r,
                           input logic [9:0] c, input logic [31:0] exp);
        start_req(1'b0, bg, ba, r, c, 32'h0, 1'b0);
        check_beats(tag, 1'b0, bg, ba, r, c, 32'h0, 8);
        check({tag, "_drain_vld"},  64'(bus.rd_resp_valid), 64'd0);
        check({tag, "_drain_rdy"},  64'(bus.req_ready), 64'd0);
        check({tag, "_drain_idle"}, 64'(busy_except(-1, -1)), 64'd0);
        @(negedge clk);
        check({tag, "_resp_vld"},  64'(bus.rd_resp_valid), 64'd1);
        check({tag, "_resp_rdy"},  64'(bus.req_ready), 64'd1);
        check({tag, "_resp_data"}, 64'(bus.rd_resp_data), 64'(exp));
        @(negedge clk);
        check({tag, "_pulse_end"}, 64'(bus.rd_resp_valid), 64'd0);
        check({tag, "_data_hold"}, 64'(bus.rd_resp_data), 64'(exp));
    endtask

    initial begin
        logic [31:0] w1, w3, w4a, w4b, w6;
        integer seed;
        seed = 32'h5eed0042;
        w1  = $random(seed);
        w3  = $random(seed);
        w4a = $random(seed);
        w4b = $random(seed);
        w6  = $random(seed);

        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_bg    = '0;
        bus.req_ba    = '0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_vld",   64'(bus.rd_resp_valid), 64'd0);
        check("rst_data",  64'(bus.rd_resp_data), 64'd0);
        check("rst_idle",  64'(busy_except(-1, -1)), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.req_ready), 64'd1);

        do_write("t1", 0, 1, 5'd1, 10'd0, w1);
        do_read("t2", 0, 1, 5'd1, 10'd0, w1);

        do_write("t3w", 1, 0, 5'd7, 10'd6, w3);
        do_read("t3r", 1, 0, 5'd7, 10'd6, w3);

        // Request A accepted, then fields switch to B with valid held high.
        start_req(1'b1, 2, 0, 5'd3, 10'd8, w4a, 1'b1);
        bus.req_bg    = 2'd1;
        bus.req_ba    = 2'd3;
        bus.req_row   = 5'd4;
        bus.req_col   = 10'd16;
        bus.req_wdata = w4b;
        check_beats("t4a", 1'b1, 2, 0, 5'd3, 10'd8, w4a, 8);
        check("t4a_end_rdy",  64'(bus.req_ready), 64'd1);
        check("t4a_end_idle", 64'(busy_except(-1, -1)), 64'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_beats("t4b", 1'b1, 1, 3, 5'd4, 10'd16, w4b, 8);
        check("t4b_end_rdy", 64'(bus.req_ready), 64'd1);
        do_read("t4ra", 2, 0, 5'd3, 10'd8, w4a);
        do_read("t4rb", 1, 3, 5'd4, 10'd16, w4b);

        start_req(1'b0, 0, 1, 5'd1, 10'd0, 32'h0, 1'b0);
        check_beats("t5", 1'b0, 0, 1, 5'd1, 10'd0, 32'h0, 3);
        check("t5_b3_col", 64'(column[0][1]), 64'd3);
        reset_n = 1'b0;
        #1;
        check("t5_rst_idle",  64'(busy_except(-1, -1)), 64'd0);
        check("t5_rst_ready", 64'(bus.req_ready), 64'd1);
        check("t5_rst_vld",   64'(bus.rd_resp_valid), 64'd0);
        check("t5_rst_data",  64'(bus.rd_resp_data), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("t5_hold_vld", 64'(bus.rd_resp_valid), 64'd0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_after_vld",  64'(bus.rd_resp_valid), 64'd0);
            check("t5_after_rdy",  64'(bus.req_ready), 64'd1);
            check("t5_after_idle", 64'(busy_except(-1, -1)), 64'd0);
        end

        do_write("t6w", 3, 3, 5'd31, 10'h3F8, w6);
        do_read("t6r", 3, 3, 5'd31, 10'h3F8, w6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
